// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline constants for the MEM stage
package mem_stage_pkg;

    localparam int MIN_W  = 49;
    localparam int MOUT_W = 39;

    // EX/MEM bundle field positions
    localparam int MIN_RR1_HI   = 48;
    localparam int MIN_RR1_LO   = 45;
    localparam int MIN_RR2_HI   = 44;
    localparam int MIN_RR2_LO   = 41;
    localparam int MIN_ALU_HI   = 40;
    localparam int MIN_ALU_LO   = 25;
    localparam int MIN_SD_HI    = 24;
    localparam int MIN_SD_LO    = 9;
    localparam int MIN_WR_HI    = 8;
    localparam int MIN_WR_LO    = 5;
    localparam int MIN_MEMWRITE = 4;
    localparam int MIN_MEMTOREG = 3;
    localparam int MIN_REGWRITE = 2;
    localparam int MIN_HALT     = 1;
    localparam int MIN_MEMREAD  = 0;

    // MEM/WB bundle field positions
    localparam int MOUT_DATA_HI  = 38;
    localparam int MOUT_DATA_LO  = 23;
    localparam int MOUT_ALU_HI   = 22;
    localparam int MOUT_ALU_LO   = 7;
    localparam int MOUT_WR_HI    = 6;
    localparam int MOUT_WR_LO    = 3;
    localparam int MOUT_MEMTOREG = 2;
    localparam int MOUT_REGWRITE = 1;
    localparam int MOUT_HALT     = 0;

    localparam int TIMEOUT_LIMIT = 16;
    localparam int CNT_W         = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_LIMIT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory request FSM with timeout counter and sticky error
module mem_ctrl
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mem_op_i,
    input  logic mem_ack_i,
    output logic req_o,
    output logic issue_o,
    output logic done_o,
    output logic err_o
);

    mem_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req_o   = 1'b0;
        issue_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_i) begin
                    req_o   = 1'b1;
                    issue_o = 1'b1;
                    if (mem_ack_i) begin
                        done_o = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                req_o = 1'b1;
                // ack wins over a timeout landing in the same cycle
                if (mem_ack_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done_o  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX/MEM and MEM/WB registers, store forwarding
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MIN_W-1:0]  M_in,
    input  logic [3:0]        wb_wr_reg,
    input  logic              wb_RegWrite,
    input  logic [15:0]       wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_stall,
    output logic [MOUT_W-1:0] M_out,
    output logic              mem_err
);

    logic [MIN_W-1:0]  ex_q, ex_d;
    logic [MOUT_W-1:0] out_q, out_d;
    logic [15:0]       wdata_q, wdata_d;

    logic        is_write, mem_op, req, issue, done;
    logic [3:0]  rr2;
    logic [15:0] alu, store_res, mem_data;
    logic        fwd;
    logic        rr1_unused;

    assign is_write   = ex_q[MIN_MEMWRITE];
    assign mem_op     = is_write | ex_q[MIN_MEMREAD];
    assign rr2        = ex_q[MIN_RR2_HI:MIN_RR2_LO];
    assign alu        = ex_q[MIN_ALU_HI:MIN_ALU_LO];
    assign rr1_unused = ^ex_q[MIN_RR1_HI:MIN_RR1_LO];

    mem_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_op_i  (mem_op),
        .mem_ack_i (mem_ack),
        .req_o     (req),
        .issue_o   (issue),
        .done_o    (done),
        .err_o     (mem_err)
    );

    // register 0 is hard-wired, so a pending write to it is never forwarded
    assign fwd       = wb_RegWrite && (wb_wr_reg == rr2) && (wb_wr_reg != 4'd0);
    assign store_res = fwd ? wb_data : ex_q[MIN_SD_HI:MIN_SD_LO];
    assign mem_stall = mem_op & ~done;

    always_comb begin
        ex_d    = mem_stall ? ex_q : M_in;
        wdata_d = issue ? store_res : wdata_q;
        mem_data = '0;
        if (req && !is_write && mem_ack) begin
            mem_data = mem_rdata;
        end
        out_d = '0;
        if (!mem_stall) begin
            out_d[MOUT_DATA_HI:MOUT_DATA_LO] = mem_data;
            out_d[MOUT_ALU_HI:MOUT_ALU_LO]   = alu;
            out_d[MOUT_WR_HI:MOUT_WR_LO]     = ex_q[MIN_WR_HI:MIN_WR_LO];
            out_d[MOUT_MEMTOREG]             = ex_q[MIN_MEMTOREG];
            out_d[MOUT_REGWRITE]             = ex_q[MIN_REGWRITE];
            out_d[MOUT_HALT]                 = ex_q[MIN_HALT];
        end
    end

    assign mem_req   = req;
    assign mem_we    = req & is_write;
    assign mem_addr  = req ? alu : 16'h0000;
    // the issue cycle drives the freshly resolved value, WAIT drives the latched one
    assign mem_wdata = req ? (issue ? store_res : wdata_q) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            out_q   <= '0;
            wdata_q <= '0;
        end else begin
            ex_q    <= ex_d;
            out_q   <= out_d;
            wdata_q <= wdata_d;
        end
    end

    assign M_out = out_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [48:0] M_in;
    logic [3:0]  wb_wr_reg;
    logic        wb_RegWrite;
    logic [15:0] wb_data;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, mem_stall;
    logic [38:0] M_out;
    logic        mem_err;

    int   total = 0;
    int   bad   = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .M_in        (M_in),
        .wb_wr_reg   (wb_wr_reg),
        .wb_RegWrite (wb_RegWrite),
        .wb_data     (wb_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_stall   (mem_stall),
        .M_out       (M_out),
        .mem_err     (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] mk(input logic [3:0] rr1, input logic [3:0] rr2,
                                       input logic [15:0] alu, input logic [15:0] sd,
                                       input logic [3:0] wr, input logic mw, input logic mtr,
                                       input logic rw, input logic halt, input logic mr);
        return {rr1, rr2, alu, sd, wr, mw, mtr, rw, halt, mr};
    endfunction

    function automatic logic [48:0] rnd_ins();
        logic [48:0] r;
        r = 49'({$urandom, $urandom});
        if ($urandom_range(0, 3) != 0 && r[4] == 1'b0 && r[0] == 1'b0) r[0] = 1'b1;
        return r;
    endfunction

    function automatic int rnd_lat();
        int k;
        k = int'($urandom_range(0, 7));
        if (k <= 4) return k;
        if (k == 5) return 7;
        if (k == 6) return 16;
        return 20;
    endfunction

    // Called at a negedge with the DUT idle; returns at the next negedge with ins held.
    task automatic load(input logic [48:0] ins);
        M_in = ins;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one already-held instruction to completion. lat = cycle index (0 = issue
    // cycle) at which ack is given; lat > 16 means no ack. nxt is presented upstream.
    task automatic do_op(input logic [48:0] ins, input logic [48:0] nxt, input int lat,
                         input logic [15:0] rd, input logic wrw, input logic [3:0] wreg,
                         input logic [15:0] wdat, input string nm);
        logic        is_wr, is_mem;
        int          cdone;
        logic [15:0] exp_wd, exp_md;
        logic [38:0] exp_out;
        is_wr   = ins[4];
        is_mem  = ins[4] | ins[0];
        cdone   = !is_mem ? 0 : (lat > 16 ? 16 : lat);
        exp_wd  = (wrw && wreg == ins[44:41] && wreg != 4'd0) ? wdat : ins[24:9];
        exp_md  = (!is_mem || is_wr || lat > 16) ? 16'h0000 : rd;
        exp_out = {exp_md, ins[40:25], ins[8:5], ins[3], ins[2], ins[1]};
        for (int i = 0; i <= cdone; i++) begin
            M_in = nxt;
            if (i == 0) begin
                wb_RegWrite = wrw;
                wb_wr_reg   = wreg;
                wb_data     = wdat;
            end else begin
                wb_RegWrite = 1'b1;
                wb_wr_reg   = ins[44:41];
                wb_data     = 16'($urandom);
            end
            mem_ack   = is_mem ? (i == lat) : 1'($urandom);
            mem_rdata = (i == lat) ? rd : 16'($urandom);
            #1;
            chk({nm, ".req"}, 64'(mem_req), 64'(is_mem));
            chk({nm, ".stall"}, 64'(mem_stall), 64'(is_mem && i < cdone));
            if (is_mem) begin
                chk({nm, ".addr"}, 64'(mem_addr), 64'(ins[40:25]));
                chk({nm, ".we"}, 64'(mem_we), 64'(is_wr));
                if (is_wr) chk({nm, ".wdata"}, 64'(mem_wdata), 64'(exp_wd));
            end else begin
                chk({nm, ".bus"}, 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
            end
            chk({nm, ".err"}, 64'(mem_err), 64'(err_m));
            @(posedge clk);
            #1;
            if (i < cdone) begin
                chk({nm, ".bubble"}, 64'(M_out), 64'd0);
            end else begin
                if (is_mem && lat > 16) err_m = 1'b1;
                chk({nm, ".out"}, 64'(M_out), 64'(exp_out));
                chk({nm, ".err_after"}, 64'(mem_err), 64'(err_m));
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [48:0] ins, cur, nxt;
        logic [3:0]  wr_sel;
        rst_n = 1'b0; M_in = '0; wb_wr_reg = '0; wb_RegWrite = 1'b0; wb_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out", 64'(M_out), 64'd0);
        chk("rst.req", 64'(mem_req), 64'd0);
        chk("rst.stall", 64'(mem_stall), 64'd0);
        chk("rst.err", 64'(mem_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        ins = mk(4'd1, 4'd2, 16'h1234, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        load(ins); do_op(ins, '0, 0, 16'h0, 1'b0, 4'd0, 16'h0, "alu");

        ins = mk(4'd0, 4'd0, 16'h0040, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(ins); do_op(ins, '0, 3, 16'hBEEF, 1'b0, 4'd0, 16'h0, "ld3");

        ins = mk(4'd0, 4'd5, 16'h0100, 16'h1111, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        load(ins); do_op(ins, '0, 4, 16'h0, 1'b1, 4'd5, 16'hA5A5, "st_fwd");

        ins = mk(4'd0, 4'd0, 16'h0200, 16'h0000, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(ins); do_op(ins, '0, 16, 16'h5A5A, 1'b0, 4'd0, 16'h0, "ld16");

        ins = mk(4'd0, 4'd0, 16'h0300, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(ins); do_op(ins, '0, 99, 16'h7777, 1'b0, 4'd0, 16'h0, "ld_to");

        ins = mk(4'd0, 4'd0, 16'h0304, 16'h0000, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(ins); do_op(ins, '0, 2, 16'h1357, 1'b0, 4'd0, 16'h0, "ld_after");

        ins = mk(4'd0, 4'd9, 16'h0400, 16'h2468, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        load(ins); do_op(ins, '0, 1, 16'hFFFF, 1'b0, 4'd0, 16'h0, "both_halt");

        ins = mk(4'd0, 4'd0, 16'h0500, 16'h0000, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(ins);
        M_in = '0; mem_ack = 1'b0;
        @(posedge clk); @(posedge clk);
        #2;
        chk("rstw.pre_req", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        err_m = 1'b0;
        #1;
        chk("rstw.req", 64'(mem_req), 64'd0);
        chk("rstw.out", 64'(M_out), 64'd0);
        chk("rstw.stall", 64'(mem_stall), 64'd0);
        chk("rstw.err", 64'(mem_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ins = mk(4'd0, 4'd0, 16'h0600, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(ins); do_op(ins, '0, 0, 16'hC0DE, 1'b0, 4'd0, 16'h0, "post_rst");

        cur = rnd_ins();
        load(cur);
        repeat (80) begin
            nxt    = rnd_ins();
            wr_sel = ($urandom_range(0, 1) == 1) ? cur[44:41] : 4'($urandom);
            do_op(cur, nxt, rnd_lat(), 16'($urandom), 1'($urandom), wr_sel,
                  16'($urandom), "rnd");
            cur = nxt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
